// File: rtl/divider32_seq_pkg.sv
// Shared ALU divider definitions: state encoding, iteration count, divide-by-zero quotient.
package divider32_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = $clog2(DIV_ITER);

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

endpackage

// File: rtl/divider32_seq_subtractor32.sv
// 32-bit ripple subtractor: difference = a - b - borrow_in, borrow_out set when the result wrapped.
module subtractor32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        borrow_in,
    output logic [31:0] difference,
    output logic        borrow_out
);

    logic [32:0] sum;

    // a + ~b + ~borrow_in; a carry out of bit 31 means no borrow.
    assign sum        = {1'b0, a} + {1'b0, ~b} + {32'd0, ~borrow_in};
    assign difference = sum[31:0];
    assign borrow_out = ~sum[32];

endmodule

// File: rtl/divider32_seq.sv
// Iterative 32-bit restoring divider, signed/unsigned DIV and REM, one quotient bit per cycle.
module divider32_seq
    import divider32_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        isSigned,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        divByZero
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      p_q, q_q, d_q;
    logic             q_neg_q, r_neg_q, dz_q;
    logic [31:0]      quotient_q, remainder_q;
    logic             div_by_zero_q, done_q;

    logic [31:0] pshift;
    logic        carry;
    logic [31:0] run_a, run_b, run_diff;
    logic        run_borrow;
    logic [31:0] neg_b, neg_diff;
    logic        neg_borrow;
    logic        accept;
    logic        dz_in;
    logic [31:0] mag_dividend, mag_divisor;

    assign pshift = {p_q[30:0], q_q[31]};
    assign carry  = p_q[31];

    // The RUN subtractor is otherwise idle, so it also negates the dividend at load and P in FIX.
    always_comb begin
        run_a = '0;
        run_b = dividend;
        unique case (state_q)
            RUN: begin
                run_a = pshift;
                run_b = d_q;
            end
            FIX:     run_b = p_q;
            default: run_b = dividend;
        endcase
    end

    assign neg_b = (state_q == FIX) ? q_q : divisor;

    subtractor32 u_sub_run (
        .a          (run_a),
        .b          (run_b),
        .borrow_in  (1'b0),
        .difference (run_diff),
        .borrow_out (run_borrow)
    );

    subtractor32 u_sub_neg (
        .a          (32'd0),
        .b          (neg_b),
        .borrow_in  (1'b0),
        .difference (neg_diff),
        .borrow_out (neg_borrow)
    );

    assign accept       = carry | ~run_borrow;
    // 0 - divisor borrows exactly when the divisor is non-zero.
    assign dz_in        = ~neg_borrow;
    assign mag_dividend = (isSigned & dividend[31]) ? run_diff : dividend;
    assign mag_divisor  = (isSigned & divisor[31]) ? neg_diff : divisor;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = dz_in ? FIX : RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            p_q           <= '0;
            q_q           <= '0;
            d_q           <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dz_q          <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= CNT_W'(DIV_ITER - 1);
                        p_q     <= '0;
                        d_q     <= mag_divisor;
                        // On divide by zero Q carries the raw dividend through to the remainder.
                        q_q     <= dz_in ? dividend : mag_dividend;
                        q_neg_q <= isSigned & (dividend[31] ^ divisor[31]);
                        r_neg_q <= isSigned & dividend[31];
                        dz_q    <= dz_in;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    p_q <= accept ? run_diff : pshift;
                    q_q <= {q_q[30:0], accept};
                end
                FIX: begin
                    if (dz_q) begin
                        quotient_q  <= DIV0_QUOTIENT;
                        remainder_q <= q_q;
                    end else begin
                        quotient_q  <= q_neg_q ? neg_diff : q_q;
                        remainder_q <= r_neg_q ? run_diff : p_q;
                    end
                    div_by_zero_q <= dz_q;
                    done_q        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign divByZero = div_by_zero_q;

endmodule

// File: tb/tb_divider32_seq.sv
// Self-checking bench for divider32_seq: directed cases plus randomized operands against an
// arithmetic reference model.
module tb_divider32_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        isSigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divByZero;

    int tests = 0;
    int fails = 0;

    divider32_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .isSigned  (isSigned),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
        int sa;
        int sb;
        sa = a;
        sb = b;
        dz = (b == 32'd0);
        if (dz) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Starts one division at the next edge (edge 0); inj > 0 pulses a stray start at that edge.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int inj, input string tag);
        logic [31:0] eq, er, pq, pr;
        logic        edz, pdz, busy_ok, hold_ok;
        int          lat, n;
        model(sgn, a, b, eq, er, edz);
        lat = edz ? 1 : 33;
        pq  = quotient;
        pr  = remainder;
        pdz = divByZero;
        start    = 1'b1;
        isSigned = sgn;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        n        = 0;
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        while (!done && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (quotient !== pq || remainder !== pr || divByZero !== pdz) hold_ok = 1'b0;
            start = (n + 1 == inj);
            @(posedge clock);
            #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
        check({tag, "_hold_prev"}, 32'(hold_ok), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_quot"}, quotient, eq);
        check({tag, "_rem"}, remainder, er);
        check({tag, "_dz"}, 32'(divByZero), 32'(edz));
        @(posedge clock);
        #1;
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_quot_hold"}, quotient, eq);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        seen_done;
        reset    = 1'b1;
        start    = 1'b0;
        isSigned = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_dz", 32'(divByZero), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 0, "u100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, "s_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0, "s_7_m2");
        run_div(1'b0, 32'd5, 32'd0, 0, "u5_0");
        run_div(1'b1, 32'd5, 32'd0, 0, "s5_0");
        run_div(1'b1, 32'hFFFFFFFB, 32'd0, 0, "s_m5_0");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "s_ovf");
        run_div(1'b0, 32'hFFFFFFFF, 32'h80000001, 0, "u_carry");
        run_div(1'b0, 32'd1000, 32'd3, 10, "start_ignored");

        // Abort mid-run with reset.
        start    = 1'b1;
        isSigned = 1'b0;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quot", quotient, 32'd0);
        check("abort_rem", remainder, 32'd0);
        check("abort_dz", 32'(divByZero), 32'd0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, 0, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFFFFFF;
                3:       ra = 32'h80000000;
                4:       rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            run_div(1'($urandom_range(0, 1)), ra, rb,
                    (i % 10 == 0) ? int'($urandom_range(2, 30)) : 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/divider32_seq.md
Name: divider32_seq

Overview:
- Iterative 32-bit restoring divider for the ALU. It sequences one shared 32-bit subtractor (`subtractor32`) over 32 cycles, producing one quotient bit per cycle.
- Supports signed and unsigned DIV/REM. It sits beside the combinational ALU, and the pipeline controller stalls on busy.

Parameters:
- None. Width is fixed at 32 to match `subtractor32`.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a division; sampled only in IDLE
- isSigned  input  1  1 = two's-complement operands, 0 = unsigned
- dividend  input  32  dividend, sampled when start is accepted
- divisor  input  32  divisor, sampled when start is accepted
- busy  output  1  high while state is not IDLE
- done  output  1  one-cycle pulse when results are valid
- quotient  output  32  quotient, held until the next accepted start
- remainder  output  32  remainder, held until the next accepted start
- divByZero  output  1  set with done when divisor was 0; held like results

Behaviour:
- Reset (async, active-high): state IDLE, counter 0, busy 0, done 0, quotient/remainder 0, divByZero 0, internal registers 0.
- States:
  - IDLE: on start=1 at an edge, latch operands and go to RUN, or to FIX if divisor==0. start in any other state is ignored.
  - RUN: 32 edges, counter 31 down to 0. After the counter==0 edge, go to FIX.
  - FIX: one edge. Registers outputs, pulses done=1, returns to IDLE.
- Load (start edge):
  - Signed: latch magnitudes |dividend| and |divisor|, treated as unsigned 32-bit; |0x80000000| = 0x80000000.
  - Unsigned: latch raw values.
  - Record qNeg = isSigned & (dividend[31] ^ divisor[31]) and rNeg = isSigned & dividend[31].
  - Partial remainder P = 0, quotient shift register Q = magnitude of dividend.
- RUN step (per edge):
  - {carry, Pshift} = {P, Q[31]}; this is 33 bits.
  - Subtractor computes Pshift − D with borrowIn=0.
  - accept = carry | ~borrowOut.
  - P <= accept ? difference : Pshift.
  - Q <= {Q[30:0], accept}.
- FIX:
  - quotient = qNeg ? −Q : Q.
  - remainder = rNeg ? −P : P.
  - Negation is 0 − x mod 2^32.
- Divide by zero path:
  - Skips RUN entirely.
  - quotient = 0xFFFFFFFF.
  - remainder = original dividend, raw, not magnitude.
  - divByZero = 1.
- Latency, with the start edge counted as edge 0:
  - Normal: done is high after edge 33 for exactly one cycle; busy is high after edges 0..32.
  - Divide by zero: done after edge 1.
- Signed overflow 0x80000000 / −1: quotient 0x80000000, remainder 0, via the normal path with no special case.
- A back-to-back start in the cycle done is high is ignored, because state is FIX→IDLE at that edge. start is accepted on the following cycle.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values, and no done is produced.
- Outputs are not modified from an accepted start until FIX. Previous results stay readable while busy.

Decomposition:
- Shared ALU package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, FIX=2'd2
  - DIV_ITER = 32
  - DIV0_QUOTIENT = 32'hFFFFFFFF
- Sub-module: one `subtractor32` instance for the RUN step.
- Negation in load/FIX uses a second `subtractor32` instance with A=0, so no `-` operator appears in the datapath.

Test Plan:
- Unsigned 100 / 7: quotient 14, remainder 2, divByZero 0; done high after edge 33; busy high edges 0..32.
- Signed −7 / 2: quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Signed 7 / −2: quotient 0xFFFFFFFD, remainder 1.
- 5 / 0 (either mode): quotient 0xFFFFFFFF, remainder 5, divByZero 1; done after edge 1.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 0x80000001 (exercises the carry path): quotient 1, remainder 0x7FFFFFFE.
- start pulsed at edge 10 of a running division: ignored, original result delivered. Reset asserted at edge 15 then released: busy 0, done never pulses, outputs 0. A new start after release gives correct results.
- Random signed/unsigned pairs (≥1000) checked against a reference model. Check done is exactly one cycle wide and results hold stable until the next accepted start.
